pdm_modulator: RTL

//  PCM-to-PDM delta-sigma transmitter; the transmitting end of the PDM link that the SoC PDM receiver consumes.

---
 rtl/soc_parameters.sv | 15 +
 rtl/pdm_sample_buffer.sv | 65 ++++++
 rtl/pdm_modulator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/soc_parameters.sv
// Purpose: shared PDM transmitter types and default sizing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package soc_parameters;

   typedef enum logic {
      PDM_IDLE = 1'b0,
      PDM_RUN  = 1'b1
   } pdm_mod_state_t;

   localparam int PDM_SAMPLE_WIDTH = 16;
   localparam int PDM_DECIMATION   = 64;
   localparam int PDM_BUFFER_DEPTH = 8;

endpackage

// File: rtl/pdm_sample_buffer.sv
// Purpose: synchronous FIFO holding PCM samples ahead of the PDM modulator.
// Latency: a push is visible at pop_dat_o on the cycle after the write; pop data is combinational.
// Backpressure: full_o blocks pushes (even with a simultaneous pop); a pop on an empty buffer is ignored.
// Ports: clk_i/rst_n_i clock and async active-low reset; push_i/push_dat_i write side;
//        pop_i/pop_dat_o read side; full_o/empty_o status.
module pdm_sample_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o    = (cnt_q == CNT_W'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/pdm_modulator.sv
// Purpose: PCM-to-PDM delta-sigma transmitter with generated PDM clock; data changes on PDM clock falls.
// Latency: entry bit on the IDLE->RUN edge, then one bit per PDM period; a sample is used at the next frame start.
// Backpressure: sample_ready_o = !full of the sample buffer; frame start on empty buffer reuses the sample and pulses underrun_o.
// Ports: clk_i, rst_n_i (async active-low), enable_i, divisor_i (half-period - 1), sample_i/sample_valid_i/sample_ready_o,
//        pdm_clk_o, pdm_data_o, underrun_o (1-cycle pulse), running_o.
// Option: define PDM_SECOND_ORDER_EN for the saturating second-order loop; otherwise first-order loop only.
module pdm_modulator
   import soc_parameters::*;
#(
   parameter int SAMPLE_WIDTH  = PDM_SAMPLE_WIDTH,
   parameter int DECIMATION    = PDM_DECIMATION,
   parameter int BUFFER_DEPTH  = PDM_BUFFER_DEPTH,
   parameter int DIVIDER_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     enable_i,
   input  logic [DIVIDER_WIDTH-1:0] divisor_i,
   input  logic [SAMPLE_WIDTH-1:0]  sample_i,
   input  logic                     sample_valid_i,
   output logic                     sample_ready_o,
   output logic                     pdm_clk_o,
   output logic                     pdm_data_o,
   output logic                     underrun_o,
   output logic                     running_o
);

   localparam int CNT_W = $clog2(DECIMATION);
   localparam int FS    = 2 ** (SAMPLE_WIDTH - 1);

   pdm_mod_state_t                  state_q, state_d;
   logic [DIVIDER_WIDTH-1:0]        div_q, div_d;
   logic [DIVIDER_WIDTH-1:0]        clk_cnt_q, clk_cnt_d;
   logic                            pdm_clk_q, pdm_clk_d;
   logic                            pdm_data_q, pdm_data_d;
   logic                            underrun_q, underrun_d;
   logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
   logic signed [SAMPLE_WIDTH-1:0]  x_q, x_d, x_sel;
   logic                            bit_ev, run_exit, pop, loop_bit;
   logic                            buf_full, buf_empty;
   logic [SAMPLE_WIDTH-1:0]         buf_dat;

   pdm_sample_buffer #(
      .WIDTH (SAMPLE_WIDTH),
      .DEPTH (BUFFER_DEPTH)
   ) u_buf (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (sample_valid_i && !buf_full),
      .push_dat_i (sample_i),
      .pop_i      (pop),
      .pop_dat_o  (buf_dat),
      .full_o     (buf_full),
      .empty_o    (buf_empty)
   );

   assign sample_ready_o = !buf_full;
   assign pdm_clk_o      = pdm_clk_q;
   assign pdm_data_o     = pdm_data_q;
   assign underrun_o     = underrun_q;
   assign running_o      = (state_q == PDM_RUN);

   // FSM and PDM clock divider. A bit event is the entry edge or a 1->0 PDM clock toggle.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      clk_cnt_d = clk_cnt_q;
      pdm_clk_d = pdm_clk_q;
      bit_ev    = 1'b0;
      run_exit  = 1'b0;
      case (state_q)
         PDM_IDLE: begin
            if (enable_i) begin
               state_d = PDM_RUN;
               div_d   = divisor_i;
               bit_ev  = 1'b1;
            end
         end
         PDM_RUN: begin
            if (!enable_i) begin
               state_d   = PDM_IDLE;
               run_exit  = 1'b1;
               clk_cnt_d = '0;
               pdm_clk_d = 1'b0;
            end else if (clk_cnt_q == div_q) begin
               clk_cnt_d = '0;
               pdm_clk_d = !pdm_clk_q;
               bit_ev    = pdm_clk_q;
            end else begin
               clk_cnt_d = clk_cnt_q + DIVIDER_WIDTH'(1);
            end
         end
         default: state_d = PDM_IDLE;
      endcase
   end

   // Frame sequencing: pop at bit 0; an empty buffer keeps the previous sample.
   always_comb begin
      pop        = bit_ev && (bit_cnt_q == '0);
      x_sel      = (pop && !buf_empty) ? signed'(buf_dat) : x_q;
      underrun_d = pop && buf_empty;
      bit_cnt_d  = bit_cnt_q;
      x_d        = x_q;
      pdm_data_d = pdm_data_q;
      if (run_exit) begin
         bit_cnt_d  = '0;
         x_d        = '0;
         pdm_data_d = 1'b0;
      end else if (bit_ev) begin
         bit_cnt_d  = bit_cnt_q + CNT_W'(1);
         x_d        = x_sel;
         pdm_data_d = loop_bit;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= PDM_IDLE;
         div_q      <= '0;
         clk_cnt_q  <= '0;
         pdm_clk_q  <= 1'b0;
         pdm_data_q <= 1'b0;
         underrun_q <= 1'b0;
         bit_cnt_q  <= '0;
         x_q        <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         clk_cnt_q  <= clk_cnt_d;
         pdm_clk_q  <= pdm_clk_d;
         pdm_data_q <= pdm_data_d;
         underrun_q <= underrun_d;
         bit_cnt_q  <= bit_cnt_d;
         x_q        <= x_d;
      end
   end

`ifdef PDM_SECOND_ORDER_EN
   localparam int INT_W = SAMPLE_WIDTH + 4;
   localparam int SUM_W = INT_W + 2;
   localparam logic signed [SUM_W-1:0] FS_S   = SUM_W'(FS);
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2 ** (INT_W - 1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

   logic signed [INT_W-1:0] i1_q, i1_d, i1_n;
   logic signed [INT_W-1:0] i2_q, i2_d, i2_n;
   logic signed [SUM_W-1:0] fb;
   logic                    prev_q, prev_d;

   function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > SAT_HI)      return SAT_HI[INT_W-1:0];
      else if (v < SAT_LO) return SAT_LO[INT_W-1:0];
      else                 return v[INT_W-1:0];
   endfunction

   // Feedback uses the previously emitted bit; both integrators see it.
   always_comb begin
      fb       = prev_q ? FS_S : -FS_S;
      i1_n     = sat(SUM_W'(i1_q) + SUM_W'(x_sel) - fb);
      i2_n     = sat(SUM_W'(i2_q) + SUM_W'(i1_n) - fb);
      loop_bit = !i2_n[INT_W-1];
      i1_d     = i1_q;
      i2_d     = i2_q;
      prev_d   = prev_q;
      if (run_exit) begin
         i1_d   = '0;
         i2_d   = '0;
         prev_d = 1'b0;
      end else if (bit_ev) begin
         i1_d   = i1_n;
         i2_d   = i2_n;
         prev_d = loop_bit;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         i1_q   <= '0;
         i2_q   <= '0;
         prev_q <= 1'b0;
      end else begin
         i1_q   <= i1_d;
         i2_q   <= i2_d;
         prev_q <= prev_d;
      end
   end
`else
   localparam int ACC_W = SAMPLE_WIDTH + 2;
   localparam logic signed [ACC_W-1:0] FS_A = ACC_W'(FS);

   logic signed [ACC_W-1:0] acc_q, acc_d, acc_v, acc_n;

   // The accumulator stays within [-FS, FS), so two guard bits suffice without saturation.
   always_comb begin
      acc_v    = acc_q + ACC_W'(x_sel);
      loop_bit = !acc_v[ACC_W-1];
      acc_n    = acc_v - (loop_bit ? FS_A : -FS_A);
      acc_d    = acc_q;
      if (run_exit)    acc_d = '0;
      else if (bit_ev) acc_d = acc_n;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) acc_q <= '0;
      else          acc_q <= acc_d;
   end
`endif

endmodule
